// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline memory stage: FSM state encoding and default parameters.
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  localparam int unsigned TIMEOUT_DEF  = 64;
  localparam logic [31:0] ERR_DATA_DEF = 32'h0000_0000;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Busy-cycle counter for the memory handshake; tc flags the last cycle before abandoning.
module mem_timeout_cnt #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic clrn,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign tc = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!clrn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: runs loads/stores over a req/ack memory port and drives MEM/WB inputs and stall.
module mem_stage_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ewmem,
  input  logic [31:0] ealu,
  input  logic [31:0] eb,
  input  logic [4:0]  ern,
  output logic        stall,
  output logic        mwreg,
  output logic        mm2reg,
  output logic [31:0] mmo,
  output logic [31:0] malu,
  output logic [4:0]  mrn,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        err_align,
  output logic        err_timeout,
  output logic        err_conflict
);

  mem_state_e  state_q, state_d;
  logic [31:0] rdata_q;
  logic        abandoned_q;
  logic        start;
  logic        tc;
  logic        mem_op;
  logic        aligned;
  logic        timed_out;

  assign mem_op    = ewmem | em2reg;
  assign aligned   = is_word_aligned(ealu);
  assign timed_out = (state_q == BUSY) && !mem_ack && tc;
  assign malu      = ealu;
  assign mrn       = ern;

  mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk  (Clk),
    .clrn (Clrn),
    .clr  (state_q != BUSY),
    .en   ((state_q == BUSY) && !mem_ack),
    .tc   (tc)
  );

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    mwreg   = 1'b0;
    mm2reg  = 1'b0;
    mmo     = 32'h0;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!mem_op) begin
          mwreg = ewreg;
        end else if (aligned) begin
          stall   = 1'b1;
          start   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (mem_ack || tc) state_d = DONE;
      end
      DONE: begin
        // A conflicting op is treated as a store, so its load flag never reaches MEM/WB.
        mwreg   = ewreg & ~abandoned_q;
        mm2reg  = em2reg & ~ewmem & ~abandoned_q;
        mmo     = rdata_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      state_q      <= IDLE;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'h0;
      mem_wdata    <= 32'h0;
      rdata_q      <= 32'h0;
      abandoned_q  <= 1'b0;
      err_align    <= 1'b0;
      err_timeout  <= 1'b0;
      err_conflict <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        mem_req     <= 1'b1;
        mem_we      <= ewmem;
        mem_addr    <= {ealu[31:2], 2'b00};
        mem_wdata   <= eb;
        abandoned_q <= 1'b0;
      end
      if (state_q == BUSY && mem_ack) begin
        mem_req <= 1'b0;
        rdata_q <= mem_rdata;
      end
      if (timed_out) begin
        mem_req     <= 1'b0;
        rdata_q     <= ERR_DATA;
        abandoned_q <= 1'b1;
        err_timeout <= 1'b1;
      end
      if (state_q == IDLE && mem_op && !aligned) err_align <= 1'b1;
      if (ewmem && em2reg) err_conflict <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed and random ops against an op-level occupancy/result model.
module tb_mem_stage_ctrl;

  localparam int          TO = 4;
  localparam logic [31:0] ED = 32'hDEAD_BEEF;

  logic        Clk = 1'b0;
  logic        Clrn = 1'b0;
  logic        ewreg = 1'b0, em2reg = 1'b0, ewmem = 1'b0;
  logic [31:0] ealu = 32'h0, eb = 32'h0;
  logic [4:0]  ern = 5'h0;
  logic        stall, mwreg, mm2reg;
  logic [31:0] mmo, malu;
  logic [4:0]  mrn;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        err_align, err_timeout, err_conflict;

  int   total = 0;
  int   bad = 0;
  logic e_align = 1'b0, e_to = 1'b0, e_conf = 1'b0;

  always #5 Clk = ~Clk;

  mem_stage_ctrl #(.TIMEOUT(TO), .ERR_DATA(ED)) dut (
    .Clk          (Clk),
    .Clrn         (Clrn),
    .ewreg        (ewreg),
    .em2reg       (em2reg),
    .ewmem        (ewmem),
    .ealu         (ealu),
    .eb           (eb),
    .ern          (ern),
    .stall        (stall),
    .mwreg        (mwreg),
    .mm2reg       (mm2reg),
    .mmo          (mmo),
    .malu         (malu),
    .mrn          (mrn),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .err_align    (err_align),
    .err_timeout  (err_timeout),
    .err_conflict (err_conflict)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_errs(input string tag);
    chk({tag, ".err_align"}, 32'(err_align), 32'(e_align));
    chk({tag, ".err_timeout"}, 32'(err_timeout), 32'(e_to));
    chk({tag, ".err_conflict"}, 32'(err_conflict), 32'(e_conf));
  endtask

  // k = cycles from mem_req rising to ack (1 = first BUSY cycle); k outside 1..TO means no ack in time.
  task automatic run_op(input string tag, input logic wreg, input logic m2reg, input logic wmem,
                        input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn,
                        input int k, input logic [31:0] rdata);
    logic        mem;
    logic        al;
    logic        acked;
    int          n;
    int          stalls;
    logic [31:0] junk;
    mem    = wmem | m2reg;
    al     = (alu % 4) == 0;
    stalls = 0;
    ewreg = wreg; em2reg = m2reg; ewmem = wmem; ealu = alu; eb = b; ern = rn;
    mem_ack = 1'($urandom_range(0, 1));
    junk = $urandom;
    mem_rdata = junk;
    @(negedge Clk);
    chk({tag, ".malu"}, malu, alu);
    chk({tag, ".mrn"}, 32'(mrn), 32'(rn));
    chk({tag, ".req0"}, 32'(mem_req), 32'd0);
    if (!mem) begin
      chk({tag, ".stall"}, 32'(stall), 32'd0);
      chk({tag, ".mwreg"}, 32'(mwreg), 32'(wreg));
      chk({tag, ".mm2reg"}, 32'(mm2reg), 32'd0);
      chk({tag, ".mmo"}, mmo, 32'd0);
    end else if (!al) begin
      chk({tag, ".stall"}, 32'(stall), 32'd0);
      chk({tag, ".mwreg"}, 32'(mwreg), 32'd0);
      chk({tag, ".mm2reg"}, 32'(mm2reg), 32'd0);
    end else begin
      chk({tag, ".stall"}, 32'(stall), 32'd1);
      chk({tag, ".mwreg"}, 32'(mwreg), 32'd0);
    end
    if (stall) stalls++;
    if (wmem && m2reg) e_conf = 1'b1;
    if (mem && !al) e_align = 1'b1;
    @(posedge Clk); #1;
    mem_ack = 1'b0;
    if (mem && al) begin
      acked = (k >= 1 && k <= TO);
      n = acked ? k : TO;
      for (int i = 1; i <= n; i++) begin
        junk = $urandom;
        mem_ack = (i == k);
        mem_rdata = (i == k) ? rdata : junk;
        @(negedge Clk);
        chk({tag, ".busy.req"}, 32'(mem_req), 32'd1);
        chk({tag, ".busy.we"}, 32'(mem_we), 32'(wmem));
        chk({tag, ".busy.addr"}, mem_addr, alu);
        chk({tag, ".busy.wdata"}, mem_wdata, b);
        chk({tag, ".busy.mwreg"}, 32'(mwreg), 32'd0);
        if (stall) stalls++;
        @(posedge Clk); #1;
      end
      if (!acked) e_to = 1'b1;
      junk = $urandom;
      mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = junk;
      @(negedge Clk);
      chk({tag, ".done.stall"}, 32'(stall), 32'd0);
      chk({tag, ".done.req"}, 32'(mem_req), 32'd0);
      chk({tag, ".done.mmo"}, mmo, acked ? rdata : ED);
      chk({tag, ".done.mwreg"}, 32'(mwreg), acked ? 32'(wreg) : 32'd0);
      chk({tag, ".done.mm2reg"}, 32'(mm2reg), acked ? 32'(m2reg & ~wmem) : 32'd0);
      chk({tag, ".stall_cycles"}, 32'(stalls), 32'(n + 1));
      @(posedge Clk); #1;
      mem_ack = 1'b0;
    end
    chk_errs(tag);
  endtask

  initial begin
    int          kind;
    int          k;
    logic [31:0] r;
    logic [31:0] a;

    // Reset held two cycles with a pending load on EX/MEM.
    Clrn = 1'b0; em2reg = 1'b1; ealu = 32'h40;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("rst.req", 32'(mem_req), 32'd0);
    chk("rst.we", 32'(mem_we), 32'd0);
    chk("rst.addr", mem_addr, 32'd0);
    chk("rst.wdata", mem_wdata, 32'd0);
    chk_errs("rst");
    @(posedge Clk); #1;
    Clrn = 1'b1; em2reg = 1'b0;
    @(negedge Clk);
    chk("rst.stall_after", 32'(stall), 32'd0);
    chk("rst.req_after", 32'(mem_req), 32'd0);
    @(posedge Clk); #1;

    run_op("alu",      1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 5'd5, 0, 32'h0);
    run_op("load",     1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd7, 3, 32'hCAFEF00D);
    run_op("store",    1'b0, 1'b0, 1'b1, 32'h44, 32'h12345678, 5'd0, 1, 32'h0);
    run_op("misalign", 1'b1, 1'b1, 1'b0, 32'h42, 32'h0, 5'd3, 1, 32'h0);
    run_op("ack_at_to",1'b1, 1'b1, 1'b0, 32'h48, 32'h0, 5'd9, TO, 32'h0BADF00D);
    run_op("timeout",  1'b1, 1'b1, 1'b0, 32'h4C, 32'h0, 5'd2, 0, 32'h0);
    run_op("conflict", 1'b1, 1'b1, 1'b1, 32'h50, 32'h55AA55AA, 5'd4, 2, 32'h11112222);

    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 4);
      k = $urandom_range(0, TO + 2);
      r = $urandom;
      a = $urandom;
      case (kind)
        0: run_op("rnd.alu",   1'($urandom_range(0, 1)), 1'b0, 1'b0, a, $urandom, 5'($urandom), k, r);
        1: run_op("rnd.load",  1'b1, 1'b1, 1'b0, a & 32'hFFFF_FFFC, 32'h0, 5'($urandom), k, r);
        2: run_op("rnd.store", 1'b0, 1'b0, 1'b1, a & 32'hFFFF_FFFC, $urandom, 5'd0, k, r);
        3: run_op("rnd.misal", 1'b1, 1'($urandom_range(0, 1)), 1'b1, a | 32'h1, 32'h0, 5'd1, k, r);
        default: run_op("rnd.conf", 1'b1, 1'b1, 1'b1, a & 32'hFFFF_FFFC, $urandom, 5'd6, k, r);
      endcase
    end

    // Reset in the middle of an access; a late ack must be ignored.
    ewreg = 1'b1; em2reg = 1'b1; ewmem = 1'b0; ealu = 32'h80; eb = 32'h0; ern = 5'd8;
    mem_ack = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("midrst.req_busy", 32'(mem_req), 32'd1);
    @(posedge Clk); #1;
    Clrn = 1'b0;
    @(posedge Clk); #1;
    Clrn = 1'b1; ewreg = 1'b1; em2reg = 1'b0; ern = 5'd12; ealu = 32'h99;
    e_align = 1'b0; e_to = 1'b0; e_conf = 1'b0;
    @(negedge Clk);
    chk("midrst.req", 32'(mem_req), 32'd0);
    chk("midrst.stall", 32'(stall), 32'd0);
    chk("midrst.mwreg", 32'(mwreg), 32'd1);
    chk_errs("midrst");
    @(posedge Clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h77777777;
    @(posedge Clk); #1;
    mem_ack = 1'b0;
    @(negedge Clk);
    chk("lateack.req", 32'(mem_req), 32'd0);
    chk("lateack.stall", 32'(stall), 32'd0);
    chk("lateack.mmo", mmo, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
